// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and the slice width used by
// the serial look-ahead adder.
package alu_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry look-ahead slice. Every carry is formed directly
// from the generate/propagate terms and cin rather than rippling through the
// slice. c3 is the carry into the top bit, which the caller needs to derive
// signed overflow.
module cla4_slice
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               cin,
  output logic [SLICE_W-1:0] s4,
  output logic               c3,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic               c1;
  logic               c2;

  // Flattened look-ahead equations for all four carries and the sum bits
  always_comb begin
    g    = a4 & b4;
    p    = a4 ^ b4;
    c1   = g[0] | (p[0] & cin);
    c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s4   = p ^ {c3, c2, c1, cin};
  end

endmodule

// File: rtl/serial_cla_adder.sv
// Serial adder/subtractor that pushes one 4-bit look-ahead slice per cycle
// through a single cla4_slice, LSB slice first, carrying between slices in a
// register. Result and {n,z,c,v} flags are valid in the one-cycle DONE state.
// Optional feature macro: SERIAL_ADDER_SUB_EN enables subtraction; when it is
// undefined the sub input is accepted but the unit always adds.
module serial_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

`ifdef SERIAL_ADDER_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  state_t             state;
  state_t             next_state;
  logic               accept;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               sub_reg;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] s4;
  logic               c3;
  logic               cout;
  logic [WIDTH-1:0]   next_result;

  // Next-state logic; a new operation is accepted from IDLE or DONE only
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = BUSY;
          accept     = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == LAST_SLICE) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          next_state = BUSY;
          accept     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Select the current operand slices and splice the new sum slice into the result
  always_comb begin
    a_slice     = a_reg[int'(cnt) * SLICE_W +: SLICE_W];
    b_slice     = b_reg[int'(cnt) * SLICE_W +: SLICE_W] ^ {SLICE_W{sub_reg}};
    next_result = result;
    next_result[int'(cnt) * SLICE_W +: SLICE_W] = s4;
  end

  cla4_slice u_slice (
    .a4   (a_slice),
    .b4   (b_slice),
    .cin  (carry),
    .s4   (s4),
    .c3   (c3),
    .cout (cout)
  );

  // Operand latch, slice counter, carry chain, result assembly and flag capture
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      flags   <= 4'b0000;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      sub_reg <= sub & SUB_EN;
      carry   <= sub & SUB_EN;
      cnt     <= '0;
    end else if (state == BUSY) begin
      result <= next_result;
      carry  <= cout;
      if (cnt == LAST_SLICE) begin
        cnt   <= '0;
        flags <= {next_result[WIDTH-1], (next_result == '0), cout, c3 ^ cout};
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered status outputs, derived from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == BUSY);
      done <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_serial_cla_adder.sv
// Self-checking bench for serial_cla_adder (WIDTH=32). Expected values come
// from a plain-arithmetic model of add/subtract with n/z/c/v flags; the model
// follows SERIAL_ADDER_SUB_EN the same way the design does.
module tb_serial_cla_adder;

  localparam int W = 32;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] obs_result;
  logic [3:0]   obs_flags;

  serial_cla_adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something unforeseen stalls the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: {n, z, c, v, result} from two's-complement arithmetic
  function automatic logic [W+3:0] model(input logic [W-1:0] op_a,
                                         input logic [W-1:0] op_b,
                                         input logic op_sub);
    logic         eff;
    logic [W-1:0] b_eff;
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         n, z, c, v;
    eff   = op_sub & SUB_ON;
    b_eff = eff ? ~op_b : op_b;
    full  = {1'b0, op_a} + {1'b0, b_eff} + {{W{1'b0}}, eff};
    r     = full[W-1:0];
    c     = full[W];
    v     = (op_a[W-1] == b_eff[W-1]) && (r[W-1] != op_a[W-1]);
    n     = r[W-1];
    z     = (r == '0);
    return {n, z, c, v, r};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete operation: pulse start, wait for done, check latency,
  // result, flags and that done is a single pulse with the result held
  task automatic applyStimulus(input string tag, input logic [W-1:0] op_a,
                               input logic [W-1:0] op_b, input logic op_sub);
    logic [W+3:0] exp;
    int           edges;
    exp = model(op_a, op_b, op_sub);
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    sub   = op_sub;
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    edges = 1;
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && edges < 40) begin
      nextCycle();
      edges++;
    end
    checkOutput({tag, "_latency"}, 64'(edges), 64'd9);
    checkOutput({tag, "_result"}, 64'(result), 64'(exp[W-1:0]));
    checkOutput({tag, "_flags"}, 64'(flags), 64'(exp[W+3:W]));
    checkOutput({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    obs_result = result;
    obs_flags  = flags;
    nextCycle();
    nextCycle();
    checkOutput({tag, "_single_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_held"}, 64'({result, flags}), 64'({exp[W-1:0], exp[W+3:W]}));
  endtask

  initial begin
    int           edges;
    int           dones;
    logic [17:0]  done_trace;
    logic [17:0]  busy_trace;
    logic [17:0]  done_exp;
    logic [17:0]  busy_exp;
    logic [W+3:0] exp1;
    logic [W+3:0] exp2;

    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    nextCycle();
    nextCycle();
    checkOutput("reset_state", 64'({busy, done, result, flags}), 64'd0);
    reset = 1'b0;
    nextCycle();

    // Carry out of every bit position
    applyStimulus("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput("wrap_result_const", 64'(obs_result), 64'h0000_0000);
    checkOutput("wrap_flags_const", 64'(obs_flags), 64'b0110);

    // Signed overflow into the sign bit
    applyStimulus("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput("ovf_result_const", 64'(obs_result), 64'h8000_0000);
    checkOutput("ovf_flags_const", 64'(obs_flags), 64'b1001);

    // Subtract with borrow, or plain add when the feature is compiled out
    applyStimulus("sub", 32'd5, 32'd7, 1'b1);
    if (SUB_ON) begin
      checkOutput("sub_result_const", 64'(obs_result), 64'hFFFF_FFFE);
      checkOutput("sub_flags_const", 64'(obs_flags), 64'b1000);
    end else begin
      checkOutput("sub_result_const", 64'(obs_result), 64'h0000_000C);
    end

    // Start pulsed with new operands in the 3rd BUSY cycle must be ignored
    exp1 = model(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    nextCycle();
    start = 1'b0;
    nextCycle();
    nextCycle();
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = 1'b1; start = 1'b1;
    nextCycle();
    start = 1'b0;
    edges = 4;
    dones = 0;
    while (edges < 20) begin
      if (done) begin
        dones++;
        checkOutput("midstart_latency", 64'(edges), 64'd9);
        checkOutput("midstart_result", 64'(result), 64'(exp1[W-1:0]));
      end
      nextCycle();
      edges++;
    end
    checkOutput("midstart_done_count", 64'(dones), 64'd1);

    // Reset in the 5th BUSY cycle abandons the operation
    @(negedge clk);
    a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; sub = 1'b0; start = 1'b1;
    nextCycle();
    start = 1'b0;
    repeat (4) nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("midreset_state", 64'({busy, done, result, flags}), 64'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      nextCycle();
    end
    checkOutput("midreset_no_done", 64'(dones), 64'd0);
    applyStimulus("after_reset", 32'd3, 32'd4, 1'b0);
    checkOutput("after_reset_const", 64'(obs_result), 64'h0000_0007);

    // Start held high through DONE: back-to-back with second operands
    // captured on the DONE edge
    exp1 = model(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
    exp2 = model(32'h8000_0000, 32'h0000_0001, 1'b1);
    @(negedge clk);
    a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5B; sub = 1'b0; start = 1'b1;
    nextCycle();
    a = 32'h8000_0000; b = 32'h0000_0001; sub = 1'b1;
    done_trace = '0;
    busy_trace = '0;
    done_exp   = 18'b10_0000_0001_0000_0000;
    busy_exp   = ~done_exp;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      done_trace[cyc-1] = done;
      busy_trace[cyc-1] = busy;
      if (cyc == 9) begin
        checkOutput("b2b_first_result", 64'({result, flags}), 64'({exp1[W-1:0], exp1[W+3:W]}));
      end
      if (cyc == 18) begin
        checkOutput("b2b_second_result", 64'({result, flags}), 64'({exp2[W-1:0], exp2[W+3:W]}));
        start = 1'b0;
      end
      nextCycle();
    end
    checkOutput("b2b_done_trace", 64'(done_trace), 64'(done_exp));
    checkOutput("b2b_busy_trace", 64'(busy_trace), 64'(busy_exp));
    checkOutput("b2b_idle_after", 64'({busy, done}), 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) ra = 32'hFFFF_FFFF;
      applyStimulus($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_cla_adder.md
SERIAL_CLA_ADDER -- requirements
Module: serial_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract (a - b).
REQ-006 SHALL have port a, input, WIDTH bits: first operand.
REQ-007 SHALL have port b, input, WIDTH bits: second operand.
REQ-008 SHALL have port busy, output, 1 bit: high while the FSM is in BUSY.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, WIDTH bits: sum or difference.
REQ-011 SHALL have port flags, output, 4 bits: {n, z, c, v}.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL latch a, b, sub and go IDLE->BUSY on an edge where start=1 in IDLE or DONE.
REQ-014 SHALL process one 4-bit slice per BUSY cycle, LSB slice first, for N = WIDTH/4 cycles.
REQ-015 SHALL feed each slice's carry-out into a carry register used as the next slice's carry-in.
REQ-016 SHALL set the initial carry-in to sub; the b slice SHALL be inverted when sub=1.
REQ-017 SHALL go BUSY->DONE after slice N-1; done=1 for exactly the one cycle in DONE.
REQ-018 SHALL go DONE->IDLE when start=0, or DONE->BUSY when start=1 (back-to-back).
REQ-019 SHALL give latency N+1 edges from the start edge to the cycle with done=1.
REQ-020 SHALL ignore start while BUSY; latched operands SHALL NOT change mid-operation.
REQ-021 SHALL assemble result in place, one slice per cycle, and hold it stable from DONE until the next accepted start.
REQ-022 SHALL define the flags as follows: c = final carry-out (for subtract, 1 = no borrow); v = carry into MSB XOR carry-out of MSB; n = result[WIDTH-1]; z = (result == 0).
REQ-023 SHALL update flags only at the BUSY->DONE transition and hold them until the next DONE.
REQ-024 SHALL keep busy = 1 exactly in BUSY; it SHALL be registered with no combinational path from start.

Reset
REQ-025 SHALL, with reset=1 at an edge, set the state to IDLE and result, flags, busy, done and the carry register to 0.
REQ-026 SHALL let reset override start on the same edge.
REQ-027 SHALL, on reset in BUSY, abandon the operation with no done pulse.

Configuration
REQ-028 SHALL, with SERIAL_ADDER_SUB_EN defined, implement subtraction per REQ-016.
REQ-029 SHALL, without SERIAL_ADDER_SUB_EN, keep the sub port present but ignore it: always add, initial carry-in 0, no b inversion.

Structure
REQ-030 SHALL take the FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the slice width constant 4 from shared package alu_pkg.
REQ-031 SHALL instantiate exactly one sub-module, cla4_slice: combinational 4-bit look-ahead adder slice (a4, b4, cin -> s4, c3, cout), with c3 used for v.
REQ-032 SHALL use a slice counter of width clog2(N), wrapping to 0 on entry to DONE.

Verification (WIDTH=32)
REQ-033 SHALL cover add 0xFFFFFFFF + 0x00000001: done exactly 9 edges after start, result 0x00000000, flags n0 z1 c1 v0.
REQ-034 SHALL cover add 0x7FFFFFFF + 0x00000001: result 0x80000000, flags n1 z0 c0 v1.
REQ-035 SHALL cover sub 5 - 7 (macro on): result 0xFFFFFFFE, flags n1 z0 c0 v0; with the macro off, the same stimulus gives 0x0000000C.
REQ-036 SHALL cover start pulsed in the 3rd BUSY cycle with new operands: ignored, result still reflects the first operands, single done pulse.
REQ-037 SHALL cover reset in the 5th BUSY cycle: next cycle IDLE, result 0, flags 0, no done; a subsequent add 3+4 gives 0x00000007.
REQ-038 SHALL cover start held high through DONE: back-to-back operation, done pulses 9 cycles apart, busy low only during the DONE cycle.
